// File: rtl/per2axi_core_arbiter.sv
// Round-robin arbiter sharing the per2axi request channel between NB_CORES requesters,
// with per-core outstanding limits. Define PER2AXI_ARB_LR_LOCK_EN to hold arbitration across LR/SC pairs.
module per2axi_core_arbiter #(
    parameter int unsigned NB_CORES        = 4,
    parameter int unsigned PER_ADDR_WIDTH  = 32,
    parameter int unsigned PER_ID_WIDTH    = 5,
    parameter int unsigned AXI_ID_WIDTH    = 3,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned LOCK_TIMEOUT    = 64
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [NB_CORES-1:0]                      core_req_i,
    input  logic [NB_CORES-1:0][PER_ADDR_WIDTH-1:0]  core_add_i,
    input  logic [NB_CORES-1:0]                      core_we_i,
    input  logic [NB_CORES-1:0][5:0]                 core_atop_i,
    input  logic [NB_CORES-1:0][31:0]                core_wdata_i,
    input  logic [NB_CORES-1:0][3:0]                 core_be_i,
    output logic [NB_CORES-1:0]                      core_gnt_o,
    output logic                                     per_req_o,
    output logic [PER_ADDR_WIDTH-1:0]                per_add_o,
    output logic                                     per_we_o,
    output logic [5:0]                               per_atop_o,
    output logic [31:0]                              per_wdata_o,
    output logic [3:0]                               per_be_o,
    output logic [PER_ID_WIDTH-1:0]                  per_id_o,
    input  logic                                     per_gnt_i,
    input  logic                                     rsp_valid_i,
    input  logic [AXI_ID_WIDTH-1:0]                  rsp_id_i,
    output logic                                     lock_active_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;

    logic [PTR_W-1:0]               r_ptr;
    logic [NB_CORES-1:0][CNT_W-1:0] r_cnt;

    logic [NB_CORES-1:0] w_elig;
    logic [NB_CORES-1:0] w_lock_ok;
    logic [NB_CORES-1:0] w_inc;
    logic [NB_CORES-1:0] w_dec;
    logic [PTR_W-1:0]    w_win;
    logic [PTR_W-1:0]    w_idx;
    logic                w_found;
    logic                w_accept;

`ifdef PER2AXI_ARB_LR_LOCK_EN
    // atop[5] flags an atomic, atop[4:0] carries the riscv_defines AMO opcode
    localparam logic [5:0]  ATOP_LR = 6'b100010;
    localparam logic [5:0]  ATOP_SC = 6'b100011;
    localparam int unsigned TMR_W   = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    typedef enum logic {
        LOCK_IDLE   = 1'b0,
        LOCK_LOCKED = 1'b1
    } lock_state_t;

    lock_state_t      r_lock_state;
    lock_state_t      w_lock_state_nxt;
    logic [PTR_W-1:0] r_owner;
    logic [PTR_W-1:0] w_owner_nxt;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_nxt;
    logic             w_win_lr;
    logic             w_win_sc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lock_state <= LOCK_IDLE;
            r_owner      <= '0;
            r_timer      <= '0;
        end else begin
            r_lock_state <= w_lock_state_nxt;
            r_owner      <= w_owner_nxt;
            r_timer      <= w_timer_nxt;
        end
    end

    // While locked, an owner SC releases first, an owner LR restarts the timer, else time out
    always_comb begin
        w_lock_state_nxt = r_lock_state;
        w_owner_nxt      = r_owner;
        w_timer_nxt      = r_timer;
        w_win_lr         = w_accept && (core_atop_i[w_win] == ATOP_LR);
        w_win_sc         = w_accept && (core_atop_i[w_win] == ATOP_SC);
        case (r_lock_state)
            LOCK_IDLE: begin
                if (w_win_lr) begin
                    w_lock_state_nxt = LOCK_LOCKED;
                    w_owner_nxt      = w_win;
                    w_timer_nxt      = '0;
                end
            end
            LOCK_LOCKED: begin
                if (w_win_sc) begin
                    w_lock_state_nxt = LOCK_IDLE;
                end else if (w_win_lr) begin
                    w_timer_nxt = '0;
                end else if (r_timer == TMR_W'(LOCK_TIMEOUT - 1)) begin
                    w_lock_state_nxt = LOCK_IDLE;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            default: w_lock_state_nxt = LOCK_IDLE;
        endcase
    end

    always_comb begin
        w_lock_ok = '0;
        for (int k = 0; k < NB_CORES; k++) begin
            w_lock_ok[k] = (r_lock_state == LOCK_IDLE) || (r_owner == PTR_W'(k));
        end
    end

    assign lock_active_o = (r_lock_state == LOCK_LOCKED);
`else
    assign w_lock_ok     = '1;
    assign lock_active_o = 1'b0;
`endif

    // Eligibility is forced low during reset so the shared bus stays quiet
    always_comb begin
        w_elig = '0;
        for (int k = 0; k < NB_CORES; k++) begin
            w_elig[k] = rst_ni && core_req_i[k] && w_lock_ok[k] &&
                        (r_cnt[k] < CNT_W'(MAX_OUTSTANDING));
        end
    end

    // First eligible core at or after r_ptr, wrapping
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < NB_CORES; i++) begin
            w_idx = PTR_W'((int'(r_ptr) + i) % int'(NB_CORES));
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_accept = w_found && per_gnt_i;

    always_comb begin
        per_req_o   = w_found;
        per_add_o   = '0;
        per_we_o    = 1'b0;
        per_atop_o  = '0;
        per_wdata_o = '0;
        per_be_o    = '0;
        per_id_o    = '0;
        core_gnt_o  = '0;
        if (w_found) begin
            per_add_o   = core_add_i[w_win];
            per_we_o    = core_we_i[w_win];
            per_atop_o  = core_atop_i[w_win];
            per_wdata_o = core_wdata_i[w_win];
            per_be_o    = core_be_i[w_win];
            per_id_o    = PER_ID_WIDTH'(1) << w_win;
            if (per_gnt_i) begin
                core_gnt_o = NB_CORES'(1) << w_win;
            end
        end
    end

    // Responses for unknown cores or empty counters are dropped
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int k = 0; k < NB_CORES; k++) begin
            w_inc[k] = w_accept && (w_win == PTR_W'(k));
            w_dec[k] = rsp_valid_i && (rsp_id_i == AXI_ID_WIDTH'(k)) && (r_cnt[k] != '0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_ptr <= (w_win == PTR_W'(NB_CORES - 1)) ? '0 : w_win + PTR_W'(1);
            end
            for (int k = 0; k < NB_CORES; k++) begin
                if (w_inc[k] && !w_dec[k]) begin
                    r_cnt[k] <= r_cnt[k] + CNT_W'(1);
                end else if (w_dec[k] && !w_inc[k]) begin
                    r_cnt[k] <= r_cnt[k] - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_per2axi_core_arbiter.sv
// Randomized and directed bench for per2axi_core_arbiter against a behavioural model.
module tb_per2axi_core_arbiter;

    localparam int NB   = 4;
    localparam int AW   = 32;
    localparam int IW   = 5;
    localparam int RW   = 3;
    localparam int MAXO = 4;
    localparam int TMO  = 64;
    localparam logic [5:0] ATOP_LR = 6'b100010;
    localparam logic [5:0] ATOP_SC = 6'b100011;

    logic                    clk = 1'b0;
    logic                    rst_ni;
    logic [NB-1:0]           core_req;
    logic [NB-1:0][AW-1:0]   core_add;
    logic [NB-1:0]           core_we;
    logic [NB-1:0][5:0]      core_atop;
    logic [NB-1:0][31:0]     core_wdata;
    logic [NB-1:0][3:0]      core_be;
    logic [NB-1:0]           core_gnt_o;
    logic                    per_req_o;
    logic [AW-1:0]           per_add_o;
    logic                    per_we_o;
    logic [5:0]              per_atop_o;
    logic [31:0]             per_wdata_o;
    logic [3:0]              per_be_o;
    logic [IW-1:0]           per_id_o;
    logic                    per_gnt;
    logic                    rsp_valid;
    logic [RW-1:0]           rsp_id;
    logic                    lock_active_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_cnt [NB];
    int m_ptr;
    bit m_locked;
    int m_owner;
    int m_timer;

    per2axi_core_arbiter #(
        .NB_CORES(NB), .PER_ADDR_WIDTH(AW), .PER_ID_WIDTH(IW), .AXI_ID_WIDTH(RW),
        .MAX_OUTSTANDING(MAXO), .LOCK_TIMEOUT(TMO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .core_req_i(core_req), .core_add_i(core_add), .core_we_i(core_we),
        .core_atop_i(core_atop), .core_wdata_i(core_wdata), .core_be_i(core_be),
        .core_gnt_o(core_gnt_o), .per_req_o(per_req_o), .per_add_o(per_add_o),
        .per_we_o(per_we_o), .per_atop_o(per_atop_o), .per_wdata_o(per_wdata_o),
        .per_be_o(per_be_o), .per_id_o(per_id_o), .per_gnt_i(per_gnt),
        .rsp_valid_i(rsp_valid), .rsp_id_i(rsp_id), .lock_active_o(lock_active_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NB; k++) m_cnt[k] = 0;
        m_ptr    = 0;
        m_locked = 1'b0;
        m_owner  = 0;
        m_timer  = 0;
    endtask

    function automatic bit lock_ok(input int k);
`ifdef PER2AXI_ARB_LR_LOCK_EN
        return !m_locked || (m_owner == k);
`else
        return (k >= 0);
`endif
    endfunction

    task automatic drive(input logic [NB-1:0] req, input logic gnt, input logic rv, input int rid);
        core_req  = req;
        per_gnt   = gnt;
        rsp_valid = rv;
        rsp_id    = RW'(rid);
        for (int k = 0; k < NB; k++) begin
            core_add[k]   = $urandom();
            core_wdata[k] = $urandom();
            core_be[k]    = 4'($urandom());
            core_we[k]    = 1'($urandom());
            core_atop[k]  = '0;
        end
    endtask

    // Check combinational outputs mid-low-phase, then advance the model across one rising edge
    task automatic cycle();
        bit found;
        bit acc;
        bit dec_ok;
        int w;
        int rid;
        #1;
        found = 1'b0;
        w     = 0;
        for (int i = 0; i < NB; i++) begin
            int k;
            k = (m_ptr + i) % NB;
            if (!found && core_req[k] && (m_cnt[k] < MAXO) && lock_ok(k)) begin
                found = 1'b1;
                w     = k;
            end
        end
        check("per_req", 64'(per_req_o), 64'(found));
        check("per_id", 64'(per_id_o), found ? (64'(1) << w) : 64'd0);
        check("core_gnt", 64'(core_gnt_o), (found && per_gnt) ? (64'(1) << w) : 64'd0);
        check("per_add", 64'(per_add_o), found ? 64'(core_add[w]) : 64'd0);
        check("per_wdata", 64'(per_wdata_o), found ? 64'(core_wdata[w]) : 64'd0);
        check("per_ctl", 64'({per_we_o, per_atop_o, per_be_o}),
              found ? 64'({core_we[w], core_atop[w], core_be[w]}) : 64'd0);
        check("lock_active", 64'(lock_active_o), 64'(m_locked));
        @(posedge clk);
        acc    = found && per_gnt;
        rid    = int'(rsp_id);
        dec_ok = rsp_valid && (rid < NB) && (m_cnt[rid % NB] > 0);
`ifdef PER2AXI_ARB_LR_LOCK_EN
        if (!m_locked) begin
            if (acc && core_atop[w] == ATOP_LR) begin
                m_locked = 1'b1;
                m_owner  = w;
                m_timer  = 0;
            end
        end else if (acc && core_atop[w] == ATOP_SC) begin
            m_locked = 1'b0;
        end else if (acc && core_atop[w] == ATOP_LR) begin
            m_timer = 0;
        end else if (m_timer == TMO - 1) begin
            m_locked = 1'b0;
        end else begin
            m_timer++;
        end
`endif
        if (dec_ok) m_cnt[rid]--;
        if (acc) begin
            m_cnt[w]++;
            m_ptr = (w + 1) % NB;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < NB; k++) begin
            while (m_cnt[k] > 0) begin
                drive('0, 1'b0, 1'b1, k);
                cycle();
            end
        end
    endtask

    initial begin
        int n;
        model_reset();
        rst_ni = 1'b0;
        drive('1, 1'b1, 1'b0, 0);
        #3;
        check("rst_req", 64'(per_req_o), 64'd0);
        check("rst_gnt", 64'(core_gnt_o), 64'd0);
        check("rst_id", 64'(per_id_o), 64'd0);
        check("rst_lock", 64'(lock_active_o), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;

        // Fairness: continuous requests rotate 0,1,2,3
        for (int i = 0; i < 8; i++) begin
            drive('1, 1'b1, 1'b0, 0);
            #1;
            check("rr_id", 64'(per_id_o), 64'(1) << (i % 4));
            cycle();
        end
        drain();

        // Outstanding limit on core 1, then unmask by one response
        for (int i = 0; i < 4; i++) begin
            drive(4'b0010, 1'b1, 1'b0, 0);
            cycle();
        end
        drive(4'b0010, 1'b1, 1'b1, 1);
        #1;
        check("limit_req", 64'(per_req_o), 64'd0);
        cycle();
        drive(4'b0010, 1'b1, 1'b0, 0);
        #1;
        check("unmask_gnt", 64'(core_gnt_o), 64'b0010);
        cycle();
        drain();

        // Same-cycle accept and response on core 2 at count 3
        for (int i = 0; i < 3; i++) begin
            drive(4'b0100, 1'b1, 1'b0, 0);
            cycle();
        end
        drive(4'b0100, 1'b1, 1'b1, 2);
        #1;
        check("same_cyc_gnt", 64'(core_gnt_o), 64'b0100);
        cycle();
        drive(4'b0100, 1'b1, 1'b0, 0);
        #1;
        check("cnt3_gnt", 64'(core_gnt_o), 64'b0100);
        cycle();
        drive(4'b0100, 1'b1, 1'b0, 0);
        #1;
        check("cnt_full_req", 64'(per_req_o), 64'd0);
        cycle();
        drain();

        // Spurious responses must not underflow core 3
        drive('0, 1'b0, 1'b1, 3);
        cycle();
        drive('0, 1'b0, 1'b1, 5);
        cycle();
        for (int i = 0; i < 4; i++) begin
            drive(4'b1000, 1'b1, 1'b0, 0);
            #1;
            check("spur_gnt", 64'(core_gnt_o), 64'b1000);
            cycle();
        end
        drive(4'b1000, 1'b1, 1'b0, 0);
        #1;
        check("spur_full_req", 64'(per_req_o), 64'd0);
        cycle();
        drain();

        // Backpressure with cores 0 and 2 (pointer is at 0 after core 3)
        for (int i = 0; i < 5; i++) begin
            drive(4'b0101, 1'b0, 1'b0, 0);
            #1;
            check("bp_gnt", 64'(core_gnt_o), 64'd0);
            check("bp_id", 64'(per_id_o), 64'b00001);
            cycle();
        end
        drive(4'b0101, 1'b1, 1'b0, 0);
        #1;
        check("bp_rel0", 64'(core_gnt_o), 64'b0001);
        cycle();
        drive(4'b0101, 1'b1, 1'b0, 0);
        #1;
        check("bp_rel2", 64'(core_gnt_o), 64'b0100);
        cycle();
        drain();

`ifdef PER2AXI_ARB_LR_LOCK_EN
        drive(4'b1000, 1'b1, 1'b0, 0);
        cycle();
        drain();
        drive('1, 1'b1, 1'b0, 0);
        core_atop[0] = ATOP_LR;
        cycle();
        drive(4'b1110, 1'b1, 1'b0, 0);
        #1;
        check("lock_block_req", 64'(per_req_o), 64'd0);
        check("lock_held", 64'(lock_active_o), 64'd1);
        cycle();
        drive('1, 1'b1, 1'b0, 0);
        core_atop[0] = ATOP_SC;
        #1;
        check("lock_sc_id", 64'(per_id_o), 64'b00001);
        cycle();
        drive('1, 1'b1, 1'b0, 0);
        #1;
        check("unlock_flag", 64'(lock_active_o), 64'd0);
        check("unlock_id", 64'(per_id_o), 64'b00010);
        cycle();
        drain();

        // Timeout release with no SC
        drive(4'b0001, 1'b1, 1'b0, 0);
        core_atop[0] = ATOP_LR;
        cycle();
        n = 0;
        while (n < 100) begin
            drive(4'b1110, 1'b1, 1'b0, 0);
            #1;
            if (!lock_active_o) break;
            n++;
            cycle();
        end
        check("lock_timeout_len", 64'(n), 64'(TMO));
        check("lock_timeout_id", 64'(per_id_o), 64'b00010);
        cycle();
        drain();
`endif

        // Asynchronous reset mid-transaction
        drive(4'b0001, 1'b1, 1'b0, 0);
`ifdef PER2AXI_ARB_LR_LOCK_EN
        core_atop[0] = ATOP_LR;
`endif
        cycle();
        drive(4'b0001, 1'b1, 1'b0, 0);
        cycle();
        drive(4'b0001, 1'b1, 1'b0, 0);
        #2;
        rst_ni = 1'b0;
        #1;
        check("mrst_req", 64'(per_req_o), 64'd0);
        check("mrst_gnt", 64'(core_gnt_o), 64'd0);
        check("mrst_lock", 64'(lock_active_o), 64'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        drive('1, 1'b1, 1'b1, 0);
        #1;
        check("mrst_ptr0", 64'(per_id_o), 64'b00001);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(4'b0001, 1'b1, 1'b0, 0);
            #1;
            check("mrst_cnt_gnt", 64'(core_gnt_o), 64'b0001);
            cycle();
        end
        drive(4'b0001, 1'b1, 1'b0, 0);
        #1;
        check("mrst_full_req", 64'(per_req_o), 64'd0);
        cycle();
        drain();

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            drive(4'($urandom()), 1'(($urandom() % 4) != 0), 1'(($urandom() % 3) == 0),
                  int'($urandom() % 6));
            for (int k = 0; k < NB; k++) begin
                case ($urandom() % 8)
                    0: core_atop[k] = ATOP_LR;
                    1: core_atop[k] = ATOP_SC;
                    2: core_atop[k] = 6'($urandom());
                    default: core_atop[k] = '0;
                endcase
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/per2axi_core_arbiter.md
# per2axi_core_arbiter

Round-robin arbiter sharing the single per2axi request channel between `NB_CORES` peripheral-interconnect requesters. Sits in front of `per2axi_req_channel`: selects one core per cycle, drives the shared per_slave request bus with a one-hot ID, and returns the downstream grant to the winner only. It also enforces a per-core limit on outstanding transactions, using the response-channel handshake as completion. Optionally, it holds arbitration on a core between its LR and SC so reservation pairs are not interleaved.

## Interface
- `NB_CORES`, 4, number of requesters; must be ≤ `PER_ID_WIDTH`
- `PER_ADDR_WIDTH`, 32, address width
- `PER_ID_WIDTH`, 5, width of the one-hot ID driven downstream
- `AXI_ID_WIDTH`, 3, width of the binary response ID
- `MAX_OUTSTANDING`, 4, maximum in-flight transactions per core (≥1)
- `LOCK_TIMEOUT`, 64, cycles before a held LR lock is forcibly released (≥1)

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset; asynchronous, active-low
- `core_req_i`  in  NB_CORES  per-core request
- `core_add_i`  in  NB_CORES×PER_ADDR_WIDTH  per-core address
- `core_we_i`  in  NB_CORES  per-core write-enable, passed through unchanged
- `core_atop_i`  in  NB_CORES×6  per-core atomic opcode
- `core_wdata_i`  in  NB_CORES×32  per-core write data
- `core_be_i`  in  NB_CORES×4  per-core byte enables
- `core_gnt_o`  out  NB_CORES  per-core grant
- `per_req_o`, `per_add_o`, `per_we_o`, `per_atop_o`, `per_wdata_o`, `per_be_o`  out  as above  shared request bus toward the request channel
- `per_id_o`  out  PER_ID_WIDTH  one-hot: bit k set means core k
- `per_gnt_i`  in  1  grant from the request channel
- `rsp_valid_i`  in  1  a transaction completed (R or B handshake)
- `rsp_id_i`  in  AXI_ID_WIDTH  binary core index of the completed transaction
- `lock_active_o`  out  1  arbitration is held by an LR lock

## Operation
- Eligible core k: `core_req_i[k]`=1, `cnt[k]` < `MAX_OUTSTANDING`, and (no lock held, or the lock owner is k).
- Winner selection:
  - The winner is the first eligible core at or after priority pointer `ptr`, scanning upward and wrapping from NB_CORES-1 to 0.
  - `per_req_o`=1 iff some core is eligible.
  - The `per_*` data outputs are muxed from the winner.
  - When no core is eligible, the data outputs are 0.
- Grant: `core_gnt_o[w]` = `per_gnt_i` & `per_req_o`. All other grant bits are 0.
- Accept = `per_req_o` & `per_gnt_i`. On accept:
  - `ptr` ← (w+1) mod NB_CORES.
  - `cnt[w]` increments.
- Response: `rsp_valid_i` with `rsp_id_i`=j decrements `cnt[j]`.
  - If j ≥ NB_CORES or `cnt[j]`=0, the response is ignored (no underflow).
  - Accept and response for the same core in the same cycle leave the counter unchanged.
- Counter width: $clog2(MAX_OUTSTANDING+1).

## Timing
- Arbitration and grant are combinational; request-to-grant is 0 cycles.
- `ptr`, counters and lock state update on the `clk_i` rising edge following an accept or response.
- A core reaching `MAX_OUTSTANDING` is masked starting the next cycle. A response unmasks it starting the next cycle.
- Reset values:
  - `ptr`=0, all `cnt`=0, lock state IDLE.
  - All outputs 0: `per_req_o`, `core_gnt_o`, `per_id_o`, `lock_active_o`.
- Reset asserted mid-transaction: all state clears immediately. In-flight counts are lost, and late responses are ignored by the underflow rule.
- `per_gnt_i` low with `per_req_o` high: the winner may change next cycle only if eligibility changes. `ptr` does not move.

## Configuration
- Macro `PER2AXI_ARB_LR_LOCK_EN`.
- When defined, a lock state machine is added with states IDLE and LOCKED.
  - IDLE → LOCKED: on accept of an `AMO_LR` opcode (encoding from riscv_defines). Owner ← w, timer ← 0.
  - LOCKED: only the owner is eligible; the timer increments each cycle.
  - LOCKED → IDLE: on accept of the owner's `AMO_SC`, or when the timer reaches `LOCK_TIMEOUT`-1.
  - A new LR from the owner while LOCKED restarts the timer.
  - `lock_active_o`=1 in LOCKED.
- When undefined, there is no lock logic and `lock_active_o` is tied to 0.

## Test plan
- Round-robin fairness: all 4 cores request continuously with `per_gnt_i`=1 → grants cycle core 0,1,2,3,0,… and `per_id_o` cycles 00001, 00010, 00100, 01000.
- Outstanding limit: core 1 alone, 4 accepts with no responses → 5th cycle `per_req_o`=0. Then `rsp_valid_i`=1 with `rsp_id_i`=1 → core 1 is granted the next cycle.
- Counter edge cases:
  - Same-cycle accept and response on core 2 with `cnt`=3 → stays 3.
  - Spurious response to core 3 with `cnt`=0 → stays 0.
- Backpressure: `per_gnt_i`=0 for 5 cycles with cores 0 and 2 requesting → `core_gnt_o`=0, winner stays core 0, `ptr` unchanged.
- Lock (macro defined):
  - Core 0 LR accepted → cores 1–3 blocked. Core 0 SC accepted → `lock_active_o` falls and core 1 wins the next cycle.
  - With no SC, the lock releases after 64 cycles.
- Reset: assert `rst_ni`=0 while `cnt[0]`=2 and LOCKED → all counters 0, `lock_active_o`=0, `ptr`=0 immediately, without waiting for a clock edge.
